decode_scoreboard: RTL and testbench
====================================

DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, architectural registers per file (integer and float files).
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dec_valid  input  1  decode stage presents an instruction.
REQ-006 SHALL have port dec_ready  output  1  instruction may issue this cycle.
REQ-007 SHALL have ports rs1_dec, rs2_dec, rs3_dec, rd_dec  input  5 each  register indices.
REQ-008 SHALL have ports rs1_use, rs2_use, rs3_use, rd_use  input  1 each  operand actually used.
REQ-009 SHALL have ports rs1_fp, rs2_fp, rs3_fp, rd_fp  input  1 each  0 = integer file, 1 = float file.
REQ-010 SHALL have port flush  input  1  squash the presented instruction (branch/trap redirect).
REQ-011 SHALL have ports wb_valid  input  1, wb_rd  input  5, wb_fp  input  1  writeback retiring a pending destination.
REQ-012 SHALL have port issue  output  1  dec_valid & dec_ready & !flush.
REQ-013 SHALL have port pending_cnt  output  7  number of set pending bits (0..64).
REQ-014 SHALL have port stall_cycles  output  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-015 SHALL hold a 2*NUM_REGS pending vector, index {fp, reg}; integer x0 bit SHALL never be set.
REQ-016 SHALL form an effective vector = pending with the same-cycle writeback bit cleared (writeback bypass).
REQ-017 SHALL flag RAW hazard when any used source maps to a set bit in the effective vector; integer x0 sources never hazard.
REQ-018 SHALL flag WAW hazard when rd_use and the rd bit (rd_fp selects file) is set in the effective vector.
REQ-019 SHALL drive dec_ready = !(RAW | WAW), combinationally; independent of dec_valid.
REQ-020 On issue with rd_use and destination not integer x0, SHALL set that pending bit next cycle.
REQ-021 On wb_valid, SHALL clear the {wb_fp, wb_rd} bit next cycle; writeback to a non-pending bit SHALL be ignored.
REQ-022 Same-cycle issue setting and writeback clearing the same bit: set SHALL win.
REQ-023 flush SHALL suppress issue for that cycle only; pending bits of already-issued instructions SHALL be unaffected.
REQ-024 stall_cycles SHALL increment when dec_valid & !dec_ready & !flush, saturating at all-ones.
REQ-025 pending_cnt SHALL reflect the registered vector (one cycle after the update).
REQ-026 Latency: hazard clearance visible in the same cycle as wb_valid (zero-cycle bypass).

Reset
REQ-027 While reset is high, the pending vector SHALL be cleared, pending_cnt = 0, stall_cycles = 0.
REQ-028 During reset, issue SHALL be 0 and dec_ready SHALL be 1; wb_valid during reset is ignored.
REQ-029 A reset asserted mid-operation SHALL discard all outstanding pending state with no further effect.

Structure
REQ-030 The shared package riscv_pkg SHALL hold NUM_REGS, the reg-file select encoding (INT=0, FP=1), and the register-index typedef.
REQ-031 The pending-bit population count SHALL be a sub-module, sb_popcount, parameterised by width.
REQ-032 The block SHALL be flat otherwise; no latches; next-state combinational, state in one clocked process.

Verification
REQ-033 Issue add rd=x5 int, next cycle present rs1=x5 int -> dec_ready=0, stall_cycles increments each cycle until wb_valid wb_rd=5 wb_fp=0, when dec_ready=1 in that same cycle.
REQ-034 Issue rd=x0 int -> pending_cnt stays 0; following rs1=x0 source never stalls.
REQ-035 Issue fp rd=f3; present int rs2=x3 -> no stall; present fp rs3=f3 -> stall (rs3_use=1); rs3_use=0 -> no stall.
REQ-036 f7 pending; same cycle wb f7 and issue new rd=f7 -> f7 remains pending, pending_cnt = 1.
REQ-037 Hazard with flush=1 -> issue=0, stall_cycles unchanged; force stall counter to all-ones -> holds value.
REQ-038 Set 3 pending bits, assert reset one cycle -> pending_cnt=0, stall_cycles=0, previously hazarding instruction issues next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: register-file size, file-select encoding and
// the architectural register-index type used across the decode scoreboard.
package riscv_pkg;

   localparam int NUM_REGS  = 32;
   localparam int REG_IDX_W = 5;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic {
      FILE_INT = 1'b0,
      FILE_FP  = 1'b1
   } reg_file_e;

   // Integer x0 is hardwired to zero, so it never owns a pending bit
   // and never causes a hazard.
   function automatic logic is_int_x0(input logic fp, input reg_idx_t r);
      return (reg_file_e'(fp) == FILE_INT) && (r == '0);
   endfunction

endpackage

// File: rtl/decode_scoreboard_if.sv
// Decode-stage / writeback bundle between the pipeline and the scoreboard.
// master = decode/writeback side, slave = scoreboard.
interface decode_scoreboard_if;
   import riscv_pkg::*;

   logic     dec_valid;
   logic     dec_ready;
   reg_idx_t rs1_dec;
   reg_idx_t rs2_dec;
   reg_idx_t rs3_dec;
   reg_idx_t rd_dec;
   logic     rs1_use;
   logic     rs2_use;
   logic     rs3_use;
   logic     rd_use;
   logic     rs1_fp;
   logic     rs2_fp;
   logic     rs3_fp;
   logic     rd_fp;
   logic     flush;
   logic     wb_valid;
   reg_idx_t wb_rd;
   logic     wb_fp;
   logic     issue;

   modport master (
      output dec_valid, rs1_dec, rs2_dec, rs3_dec, rd_dec,
      output rs1_use, rs2_use, rs3_use, rd_use,
      output rs1_fp, rs2_fp, rs3_fp, rd_fp,
      output flush, wb_valid, wb_rd, wb_fp,
      input  dec_ready, issue
   );

   modport slave (
      input  dec_valid, rs1_dec, rs2_dec, rs3_dec, rd_dec,
      input  rs1_use, rs2_use, rs3_use, rd_use,
      input  rs1_fp, rs2_fp, rs3_fp, rd_fp,
      input  flush, wb_valid, wb_rd, wb_fp,
      output dec_ready, issue
   );

endinterface

// File: rtl/sb_popcount.sv
// Population count of a bit vector, purely combinational.
module sb_popcount #(
   parameter int WIDTH = 64,
   parameter int OUT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] bits,
   output logic [OUT_W-1:0] count
);

   // Sum every bit of the vector into the count.
   always_comb begin
      count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count = count + OUT_W'(bits[i]);
      end
   end

endmodule

// File: rtl/decode_scoreboard.sv
// In-order decode scoreboard: tracks pending destinations of the integer and
// float register files, stalls decode on RAW/WAW hazards, and lets a
// same-cycle writeback clear a hazard without a bubble.
module decode_scoreboard
   import riscv_pkg::*;
#(
   parameter int NUM_REGS = riscv_pkg::NUM_REGS,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   decode_scoreboard_if.slave  bus,
   output logic [6:0]          pending_cnt,
   output logic [CNT_W-1:0]    stall_cycles
);

   localparam int VEC_W = 2 * NUM_REGS;
   localparam int IDX_W = $clog2(VEC_W);

   logic [VEC_W-1:0] pending_q;
   logic [VEC_W-1:0] pending_d;
   logic [VEC_W-1:0] effective;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] stall_d;
   logic             raw;
   logic             waw;
   logic             ready;
   logic             fire;

   // Float registers live in the upper half of the pending vector.
   function automatic logic [IDX_W-1:0] bit_index(input logic fp, input reg_idx_t r);
      return fp ? (IDX_W'(NUM_REGS) + IDX_W'(r)) : IDX_W'(r);
   endfunction

   function automatic logic operand_busy(input logic [VEC_W-1:0] vec, input logic use_op,
                                         input logic fp, input reg_idx_t r);
      return use_op && !is_int_x0(fp, r) && vec[bit_index(fp, r)];
   endfunction

   // Hazard detection against the writeback-bypassed view, plus next-state
   // for the pending vector (set beats clear) and the saturating stall count.
   always_comb begin
      effective = pending_q;
      if (bus.wb_valid) begin
         effective[bit_index(bus.wb_fp, bus.wb_rd)] = 1'b0;
      end

      raw = operand_busy(effective, bus.rs1_use, bus.rs1_fp, bus.rs1_dec)
          | operand_busy(effective, bus.rs2_use, bus.rs2_fp, bus.rs2_dec)
          | operand_busy(effective, bus.rs3_use, bus.rs3_fp, bus.rs3_dec);
      waw = operand_busy(effective, bus.rd_use, bus.rd_fp, bus.rd_dec);

      ready = reset ? 1'b1 : !(raw | waw);
      fire  = !reset && bus.dec_valid && ready && !bus.flush;

      pending_d = effective;
      if (fire && bus.rd_use && !is_int_x0(bus.rd_fp, bus.rd_dec)) begin
         pending_d[bit_index(bus.rd_fp, bus.rd_dec)] = 1'b1;
      end

      stall_d = stall_q;
      if (bus.dec_valid && !ready && !bus.flush && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end

      bus.dec_ready = ready;
      bus.issue     = fire;
   end

   // State register; reset discards all outstanding pending destinations.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         stall_q   <= '0;
      end else begin
         pending_q <= pending_d;
         stall_q   <= stall_d;
      end
   end

   assign stall_cycles = stall_q;

   sb_popcount #(
      .WIDTH (VEC_W),
      .OUT_W (7)
   ) u_popcount (
      .bits  (pending_q),
      .count (pending_cnt)
   );

endmodule

// File: tb/tb_decode_scoreboard.sv
// Randomised + directed bench for decode_scoreboard with a queue-based
// scoreboard and a register-array reference model.
module tb_decode_scoreboard;
   import riscv_pkg::*;

   localparam int CNT_W     = 4;
   localparam int STALL_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic            valid;
      logic [2:0][4:0] rs;
      logic [2:0]      rs_use;
      logic [2:0]      rs_fp;
      logic [4:0]      rd;
      logic            rd_use;
      logic            rd_fp;
      logic            flush;
      logic            wb_valid;
      logic [4:0]      wb_rd;
      logic            wb_fp;
      logic            rst;
   } stim_t;

   typedef struct packed {
      logic [31:0]      cycle;
      logic             ready;
      logic             issue;
      logic [6:0]       cnt;
      logic [CNT_W-1:0] stall;
   } expect_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [6:0]       pending_cnt;
   logic [CNT_W-1:0] stall_cycles;

   expect_t exp_q[$];
   int      tests = 0;
   int      fails = 0;
   int      cycle_no = 0;

   bit      pend[2][32];
   int      stall_model = 0;

   decode_scoreboard_if sb_bus();

   decode_scoreboard #(
      .NUM_REGS (32),
      .CNT_W    (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (sb_bus),
      .pending_cnt  (pending_cnt),
      .stall_cycles (stall_cycles)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic int model_count();
      int n;
      n = 0;
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < 32; r++)
            n += int'(pend[f][r]);
      return n;
   endfunction

   // A used operand is blocked if its register is outstanding and not being
   // written back in this same cycle; integer x0 is always free.
   function automatic bit busy(logic use_op, logic fp, logic [4:0] r, stim_t s);
      if (!use_op) return 1'b0;
      if (!fp && r == 5'd0) return 1'b0;
      if (s.wb_valid && s.wb_fp == fp && s.wb_rd == r) return 1'b0;
      return pend[fp][r];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got,
                              input logic [31:0] want, input int cyc);
      tests++;
      if (got !== want) begin
         fails++;
         $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, got, want);
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      expect_t e;
      bit      hazard;
      @(posedge clk);
      #1;
      reset             = s.rst;
      sb_bus.dec_valid  = s.valid;
      sb_bus.rs1_dec    = s.rs[0];
      sb_bus.rs2_dec    = s.rs[1];
      sb_bus.rs3_dec    = s.rs[2];
      sb_bus.rs1_use    = s.rs_use[0];
      sb_bus.rs2_use    = s.rs_use[1];
      sb_bus.rs3_use    = s.rs_use[2];
      sb_bus.rs1_fp     = s.rs_fp[0];
      sb_bus.rs2_fp     = s.rs_fp[1];
      sb_bus.rs3_fp     = s.rs_fp[2];
      sb_bus.rd_dec     = s.rd;
      sb_bus.rd_use     = s.rd_use;
      sb_bus.rd_fp      = s.rd_fp;
      sb_bus.flush      = s.flush;
      sb_bus.wb_valid   = s.wb_valid;
      sb_bus.wb_rd      = s.wb_rd;
      sb_bus.wb_fp      = s.wb_fp;
      cycle_no++;

      e.cycle = 32'(cycle_no);
      e.cnt   = 7'(model_count());
      e.stall = CNT_W'(stall_model);
      if (s.rst) begin
         e.ready = 1'b1;
         e.issue = 1'b0;
         exp_q.push_back(e);
         for (int f = 0; f < 2; f++)
            for (int r = 0; r < 32; r++)
               pend[f][r] = 1'b0;
         stall_model = 0;
      end else begin
         hazard = busy(s.rs_use[0], s.rs_fp[0], s.rs[0], s)
                | busy(s.rs_use[1], s.rs_fp[1], s.rs[1], s)
                | busy(s.rs_use[2], s.rs_fp[2], s.rs[2], s)
                | busy(s.rd_use, s.rd_fp, s.rd, s);
         e.ready = !hazard;
         e.issue = s.valid && !hazard && !s.flush;
         exp_q.push_back(e);
         if (s.wb_valid) pend[s.wb_fp][s.wb_rd] = 1'b0;
         if (e.issue && s.rd_use && !(!s.rd_fp && s.rd == 5'd0))
            pend[s.rd_fp][s.rd] = 1'b1;
         if (s.valid && hazard && !s.flush && stall_model < STALL_MAX)
            stall_model++;
      end
   endtask

   // Monitor: pops one expectation per presented cycle and compares.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         expect_t e;
         e = exp_q.pop_front();
         checkOutput("dec_ready",    32'(sb_bus.dec_ready), 32'(e.ready), int'(e.cycle));
         checkOutput("issue",        32'(sb_bus.issue),     32'(e.issue), int'(e.cycle));
         checkOutput("pending_cnt",  32'(pending_cnt),      32'(e.cnt),   int'(e.cycle));
         checkOutput("stall_cycles", 32'(stall_cycles),     32'(e.stall), int'(e.cycle));
      end
   end

   // Directed scenarios followed by a randomised phase.
   initial begin
      stim_t s;
      sb_bus.dec_valid = 1'b0;
      sb_bus.rs1_dec = '0; sb_bus.rs2_dec = '0; sb_bus.rs3_dec = '0; sb_bus.rd_dec = '0;
      sb_bus.rs1_use = 1'b0; sb_bus.rs2_use = 1'b0; sb_bus.rs3_use = 1'b0; sb_bus.rd_use = 1'b0;
      sb_bus.rs1_fp = 1'b0; sb_bus.rs2_fp = 1'b0; sb_bus.rs3_fp = 1'b0; sb_bus.rd_fp = 1'b0;
      sb_bus.flush = 1'b0; sb_bus.wb_valid = 1'b0; sb_bus.wb_rd = '0; sb_bus.wb_fp = 1'b0;

      s = idle(); s.rst = 1'b1;
      applyStimulus(s);
      s.wb_valid = 1'b1; s.wb_rd = 5'd9;
      applyStimulus(s);

      // RAW on x5 stalls until its writeback, cleared in the same cycle.
      s = idle(); s.valid = 1'b1; s.rd = 5'd5; s.rd_use = 1'b1;
      applyStimulus(s);
      s = idle(); s.valid = 1'b1; s.rs[0] = 5'd5; s.rs_use[0] = 1'b1;
      repeat (3) applyStimulus(s);
      s.wb_valid = 1'b1; s.wb_rd = 5'd5;
      applyStimulus(s);

      // x0 destination never becomes pending; x0 source never stalls.
      s = idle(); s.valid = 1'b1; s.rd = 5'd0; s.rd_use = 1'b1;
      applyStimulus(s);
      s = idle(); s.valid = 1'b1; s.rs[0] = 5'd0; s.rs_use[0] = 1'b1;
      applyStimulus(s);

      // f3 pending: integer x3 is free, f3 via rs3 stalls only when used.
      s = idle(); s.valid = 1'b1; s.rd = 5'd3; s.rd_use = 1'b1; s.rd_fp = 1'b1;
      applyStimulus(s);
      s = idle(); s.valid = 1'b1; s.rs[1] = 5'd3; s.rs_use[1] = 1'b1;
      applyStimulus(s);
      s = idle(); s.valid = 1'b1; s.rs[2] = 5'd3; s.rs_fp[2] = 1'b1; s.rs_use[2] = 1'b1;
      applyStimulus(s);
      s.rs_use[2] = 1'b0;
      applyStimulus(s);

      // f7: writeback and re-issue in one cycle leaves f7 pending.
      s = idle(); s.valid = 1'b1; s.rd = 5'd7; s.rd_use = 1'b1; s.rd_fp = 1'b1;
      applyStimulus(s);
      s.wb_valid = 1'b1; s.wb_rd = 5'd7; s.wb_fp = 1'b1;
      applyStimulus(s);
      applyStimulus(idle());

      // Flushed hazard does not count; then saturate the stall counter.
      s = idle(); s.valid = 1'b1; s.rs[0] = 5'd3; s.rs_fp[0] = 1'b1; s.rs_use[0] = 1'b1;
      s.flush = 1'b1;
      applyStimulus(s);
      s.flush = 1'b0;
      repeat (STALL_MAX + 4) applyStimulus(s);

      // Reset with outstanding bits, then the hazarding instruction issues.
      s = idle(); s.valid = 1'b1; s.rd = 5'd12; s.rd_use = 1'b1;
      applyStimulus(s);
      s = idle(); s.valid = 1'b1; s.rs[0] = 5'd12; s.rs_use[0] = 1'b1;
      applyStimulus(s);
      s.rst = 1'b1;
      applyStimulus(s);
      s.rst = 1'b0;
      applyStimulus(s);
      applyStimulus(idle());

      // Random traffic over a small register window to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         s = idle();
         s.valid    = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 3; k++) begin
            s.rs[k]     = 5'($urandom_range(0, 7));
            s.rs_use[k] = 1'($urandom_range(0, 1));
            s.rs_fp[k]  = 1'($urandom_range(0, 1));
         end
         s.rd       = 5'($urandom_range(0, 7));
         s.rd_use   = 1'($urandom_range(0, 1));
         s.rd_fp    = 1'($urandom_range(0, 1));
         s.flush    = ($urandom_range(0, 7) == 0);
         s.wb_valid = ($urandom_range(0, 2) != 0);
         s.wb_rd    = 5'($urandom_range(0, 7));
         s.wb_fp    = 1'($urandom_range(0, 1));
         s.rst      = ($urandom_range(0, 59) == 0);
         applyStimulus(s);
      end
      applyStimulus(idle());

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
